block_stream_tx: RTL
====================

BLOCK_STREAM_TX -- requirements
Module: block_stream_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter BLOCK_DIM, default 8, block edge in pixels (power of 2); a block is BLOCK_DIM*BLOCK_DIM samples.
REQ-003 Parameter ADDR_WIDTH, default 20, frame-buffer address width.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to stream one frame.
REQ-007 frame_width  in  16  frame width in pixels, multiple of BLOCK_DIM, sampled on accepted start.
REQ-008 frame_height  in  16  frame height in pixels, multiple of BLOCK_DIM, sampled on accepted start.
REQ-009 block_ready  in  1  downstream (noise-estimation side) can accept the next block.
REQ-010 mem_rd_en  out  1  frame-buffer read strobe.
REQ-011 mem_addr  out  ADDR_WIDTH  read address, y*frame_width + x, truncated to ADDR_WIDTH.
REQ-012 mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
REQ-013 data_out  out  DATA_WIDTH  streamed pixel.
REQ-014 data_valid  out  1  data_out qualifier.
REQ-015 start_of_frame  out  1  high with the first pixel of the frame only.
REQ-016 end_of_frame  out  1  high with the last pixel of the frame only.
REQ-017 start_of_block / end_of_block  out  1 each  high with first / last pixel of each block.
REQ-018 busy  out  1  high from accepted start until the frame's last pixel has been emitted.

Function
REQ-019 States: IDLE, WAIT_READY, STREAM, DRAIN.
REQ-020 IDLE -> WAIT_READY when start=1 and both dimensions nonzero; dimensions latched; block position reset to (0,0); otherwise start ignored.
REQ-021 WAIT_READY -> STREAM when block_ready=1 (sampled only in WAIT_READY); no reads while block_ready=0.
REQ-022 STREAM: one read per cycle, BLOCK_DIM*BLOCK_DIM consecutive cycles, raster order inside block (x fastest), no stalls inside a block.
REQ-023 After the block's last read, STREAM -> DRAIN for exactly one cycle.
REQ-024 DRAIN -> IDLE if the block was the frame's last, else WAIT_READY.
REQ-025 Blocks ordered raster over the frame: block column fastest, then block row.
REQ-026 data_valid, data_out and all markers are mem_rd_en-based signals delayed one cycle; latency read-to-output = 1 cycle.
REQ-027 Single-block frame: start_of_frame and start_of_block coincide; end_of_frame and end_of_block coincide.
REQ-028 start asserted while busy is ignored; dimension inputs changing mid-frame have no effect.
REQ-029 Block counter and pixel counters are 32-bit, wrap not permitted within a legal frame (max 65535x65535).

Reset
REQ-030 On rst_n=0: state IDLE, busy=0, mem_rd_en=0, mem_addr=0, data_out=0, data_valid=0, all markers 0, counters 0.
REQ-031 Reset mid-frame abandons the frame; no further output until a new accepted start.

Configuration
REQ-032 Macro BLOCK_STREAM_TX_COUNT_EN defined: adds outputs blocks_per_frame [31:0] ((W/BLOCK_DIM)*(H/BLOCK_DIM), latched at accepted start, 0 at reset) and block_idx [31:0] (index of block currently being emitted on data_out, 0-based).
REQ-033 Macro undefined: those ports and their logic absent; all other behaviour identical.

Verification
REQ-034 16x8 frame, block_ready=1 -> 2 blocks, 128 data_valid cycles, addresses block0: 0..7,16..23,...,112..119; block1: 8..15,...,120..127; end_of_frame on pixel 128.
REQ-035 block_ready=0 for 20 cycles after start -> busy=1, mem_rd_en=0 throughout; first read the cycle after block_ready rises.
REQ-036 start pulsed during block 1 of a 16x16 frame -> ignored; exactly 4 blocks, one start_of_frame.
REQ-037 rst_n low at pixel 30 of block 0 -> all outputs 0 next edge; no data_valid until next start.
REQ-038 start with frame_width=0 -> remains IDLE, busy=0; 8x8 frame -> single block, all four markers correct.
REQ-039 With BLOCK_STREAM_TX_COUNT_EN, 32x16 frame -> blocks_per_frame=8; block_idx steps 0..7.

Source files
------------

// File: rtl/block_stream_tx.sv
// -----------------------------------------------------------------------------
// block_stream_tx
// Reads a frame from a frame buffer in BLOCK_DIM x BLOCK_DIM tiles and streams
// it out one pixel per cycle. Blocks are visited in raster order (block column
// fastest). Pixels inside a block are also visited in raster order (x fastest).
// Each block is released only when the downstream consumer raises block_ready.
// Once a block starts, it is read without stalls.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle frame request; accepted only when idle and
//                       both dimensions are nonzero
//   frame_width/height  frame size in pixels, multiples of BLOCK_DIM, latched
//                       on an accepted start
//   block_ready         downstream can take the next block
//   mem_rd_en/mem_addr  frame-buffer read port, addr = y*frame_width + x
//   mem_rdata           read data, valid the cycle after mem_rd_en
//   data_out/data_valid streamed pixel and qualifier (read + 1 cycle)
//   start_/end_of_frame first / last pixel of the frame
//   start_/end_of_block first / last pixel of each block
//   busy                accepted start .. last pixel emitted
//
// Optional feature (macro BLOCK_STREAM_TX_COUNT_EN):
//   blocks_per_frame    (W/BLOCK_DIM)*(H/BLOCK_DIM), latched on accepted start
//   block_idx           0-based index of the block currently on data_out
// -----------------------------------------------------------------------------
module block_stream_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BLOCK_DIM  = 8,
  parameter int unsigned ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  input  logic                  block_ready,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  start_of_frame,
  output logic                  end_of_frame,
  output logic                  start_of_block,
  output logic                  end_of_block,
  output logic                  busy
`ifdef BLOCK_STREAM_TX_COUNT_EN
  ,
  output logic [31:0]           blocks_per_frame,
  output logic [31:0]           block_idx
`endif
);

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned LOG2_BD = $clog2(BLOCK_DIM);
  localparam logic [CNT_W-1:0] BD_W   = CNT_W'(BLOCK_DIM);
  localparam logic [CNT_W-1:0] BD_MAX = CNT_W'(BLOCK_DIM - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    STREAM     = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_issue;

  // Latched frame geometry
  logic [15:0]      r_fw;
  logic [15:0]      r_fh;
  logic [CNT_W-1:0] r_span;       // (BLOCK_DIM-1) * frame_width

  // Position of the next pixel to be read
  logic [CNT_W-1:0] r_px;         // x inside block
  logic [CNT_W-1:0] r_py;         // y inside block
  logic [CNT_W-1:0] r_col_base;   // x of current block's left edge
  logic [CNT_W-1:0] r_row_base;   // y of current block row's top edge
  logic [CNT_W-1:0] r_line_addr;  // (r_row_base + r_py) * frame_width
  logic [CNT_W-1:0] r_blk_cnt;    // index of the block being read

  // Read stage (aligned with mem_rd_en)
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_sof_s1;
  logic                  r_eof_s1;
  logic                  r_sob_s1;
  logic                  r_eob_s1;

  // Output stage (aligned with mem_rdata)
  logic r_valid;
  logic r_sof;
  logic r_eof;
  logic r_sob;
  logic r_eob;
  logic r_busy;

  logic             w_last_px;
  logic             w_last_py;
  logic             w_last_col;
  logic             w_last_row;
  logic [CNT_W-1:0] w_addr_sum;

  assign w_last_px  = (r_px == BD_MAX);
  assign w_last_py  = (r_py == BD_MAX);
  assign w_last_col = ((r_col_base + BD_W) == CNT_W'(r_fw));
  assign w_last_row = ((r_row_base + BD_W) == CNT_W'(r_fh));
  assign w_addr_sum = r_line_addr + r_col_base + r_px;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; w_issue marks a cycle whose following cycle carries a read
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (frame_width != 16'd0) && (frame_height != 16'd0)) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (block_ready) begin
          w_issue     = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        // The block's last read is on the port now; leave after it
        if (r_eob_s1) begin
          w_state_nxt = DRAIN;
        end else begin
          w_issue = 1'b1;
        end
      end
      DRAIN: begin
        // r_eof is high exactly in the DRAIN cycle that follows the frame's last read
        w_state_nxt = r_eof ? IDLE : WAIT_READY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame geometry and read-position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fw        <= '0;
      r_fh        <= '0;
      r_span      <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_col_base  <= '0;
      r_row_base  <= '0;
      r_line_addr <= '0;
      r_blk_cnt   <= '0;
    end else if (w_accept) begin
      r_fw        <= frame_width;
      r_fh        <= frame_height;
      r_span      <= (CNT_W'(frame_width) << LOG2_BD) - CNT_W'(frame_width);
      r_px        <= '0;
      r_py        <= '0;
      r_col_base  <= '0;
      r_row_base  <= '0;
      r_line_addr <= '0;
      r_blk_cnt   <= '0;
    end else if (w_issue) begin
      if (w_last_px) begin
        r_px <= '0;
        if (w_last_py) begin
          r_py      <= '0;
          r_blk_cnt <= r_blk_cnt + CNT_W'(1);
          if (w_last_col) begin
            // Next block row: one line below the block's last line
            r_col_base  <= '0;
            r_row_base  <= r_row_base + BD_W;
            r_line_addr <= r_line_addr + CNT_W'(r_fw);
          end else begin
            // Next block to the right: back up to the block's first line
            r_col_base  <= r_col_base + BD_W;
            r_line_addr <= r_line_addr - r_span;
          end
        end else begin
          r_py        <= r_py + CNT_W'(1);
          r_line_addr <= r_line_addr + CNT_W'(r_fw);
        end
      end else begin
        r_px <= r_px + CNT_W'(1);
      end
    end
  end

  // Read stage: strobe, address and markers for the pixel being read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
      r_sof_s1 <= 1'b0;
      r_eof_s1 <= 1'b0;
      r_sob_s1 <= 1'b0;
      r_eob_s1 <= 1'b0;
    end else begin
      r_rd_en  <= w_issue;
      r_sof_s1 <= 1'b0;
      r_eof_s1 <= 1'b0;
      r_sob_s1 <= 1'b0;
      r_eob_s1 <= 1'b0;
      if (w_issue) begin
        r_addr   <= ADDR_WIDTH'(w_addr_sum);
        r_sob_s1 <= (r_px == '0) && (r_py == '0);
        r_eob_s1 <= w_last_px && w_last_py;
        r_sof_s1 <= (r_px == '0) && (r_py == '0) && (r_blk_cnt == '0);
        r_eof_s1 <= w_last_px && w_last_py && w_last_col && w_last_row;
      end
    end
  end

  // Output stage: read-stage signals delayed one cycle to meet the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_sob   <= 1'b0;
      r_eob   <= 1'b0;
    end else begin
      r_valid <= r_rd_en;
      r_sof   <= r_sof_s1;
      r_eof   <= r_eof_s1;
      r_sob   <= r_sob_s1;
      r_eob   <= r_eob_s1;
    end
  end

  // Busy spans accepted start through the cycle carrying end_of_frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
    end else if (r_eof) begin
      r_busy <= 1'b0;
    end
  end

`ifdef BLOCK_STREAM_TX_COUNT_EN
  logic [CNT_W-1:0] r_blk_s1;
  logic [CNT_W-1:0] r_blk_idx;
  logic [CNT_W-1:0] r_bpf;

  // Block count and per-pixel block index, pipelined like the markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_s1  <= '0;
      r_blk_idx <= '0;
      r_bpf     <= '0;
    end else begin
      if (w_accept) begin
        r_bpf <= CNT_W'(frame_width >> LOG2_BD) * CNT_W'(frame_height >> LOG2_BD);
      end
      if (w_issue) begin
        r_blk_s1 <= r_blk_cnt;
      end
      if (r_rd_en) begin
        r_blk_idx <= r_blk_s1;
      end
    end
  end

  assign blocks_per_frame = r_bpf;
  assign block_idx        = r_blk_idx;
`endif

  assign mem_rd_en      = r_rd_en;
  assign mem_addr       = r_addr;
  assign data_valid     = r_valid;
  assign start_of_frame = r_sof;
  assign end_of_frame   = r_eof;
  assign start_of_block = r_sob;
  assign end_of_block   = r_eob;
  assign busy           = r_busy;

  // Read data arrives in the data_valid cycle itself, so it is forwarded
  // rather than registered; gating keeps data_out at zero between pixels.
  assign data_out = r_valid ? mem_rdata : '0;

endmodule
